// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection and flush bubbles.
// Define ID_EX_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module id_ex_hazard_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [6:0]        id_opcode,
   input  logic [9:0]        id_ctrl,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   id_rd1,
   input  logic [XLEN-1:0]   id_rd2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [2:0]        id_funct3,
   input  logic [6:0]        id_funct7,
   input  logic              hold_in,
   input  logic              ex_flush,
   output logic [9:0]        ex_ctrl,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_rd1,
   output logic [XLEN-1:0]   ex_rd2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [2:0]        ex_funct3,
   output logic [6:0]        ex_funct7,
`ifdef ID_EX_PERF_CNT_EN
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt,
`endif
   output logic              pc_write,
   output logic              if_id_write,
   output logic              stall
);

   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpRType  = 7'b0110011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;

   logic usesRs1;
   logic usesRs2;
   logic loadUse;
   logic insertBubble;

   always_comb begin
      usesRs1 = (id_opcode != OpLui) && (id_opcode != OpJal);
      usesRs2 = (id_opcode == OpRType) || (id_opcode == OpStore) || (id_opcode == OpBranch);
   end

   // A load in EX whose destination feeds the instruction in ID; x0 never counts.
   assign loadUse = ex_valid & ex_ctrl[3] & (ex_rd != '0) & id_valid &
                    ((usesRs1 & (ex_rd == id_rs1)) | (usesRs2 & (ex_rd == id_rs2)));

   // A flush kills the dependent instruction anyway, so it suppresses the stall.
   assign stall        = loadUse & ~ex_flush & ~hold_in;
   assign pc_write     = ~(stall | hold_in);
   assign if_id_write  = ~(stall | hold_in);
   assign insertBubble = ex_flush | loadUse;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_ctrl   <= '0;
         ex_valid  <= 1'b0;
         ex_pc     <= '0;
         ex_rd1    <= '0;
         ex_rd2    <= '0;
         ex_imm    <= '0;
         ex_rs1    <= '0;
         ex_rs2    <= '0;
         ex_rd     <= '0;
         ex_funct3 <= '0;
         ex_funct7 <= '0;
      end else if (!hold_in) begin
         ex_pc     <= id_pc;
         ex_rd1    <= id_rd1;
         ex_rd2    <= id_rd2;
         ex_imm    <= id_imm;
         ex_rs1    <= id_rs1;
         ex_rs2    <= id_rs2;
         ex_rd     <= id_rd;
         ex_funct3 <= id_funct3;
         ex_funct7 <= id_funct7;
         ex_valid  <= id_valid & ~insertBubble;
         ex_ctrl   <= (id_valid & ~insertBubble) ? id_ctrl : '0;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!hold_in) begin
         if (stall)
            stall_cnt <= stall_cnt + 32'd1;
         if (ex_flush)
            flush_cnt <= flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed self-checking bench for id_ex_hazard_stage (optionally with ID_EX_PERF_CNT_EN).
`timescale 1ns/1ps
module tb_id_ex_hazard_stage;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [9:0] CTRL_LW  = 10'h00F;
   localparam logic [9:0] CTRL_ADD = 10'h044;
   localparam logic [9:0] CTRL_LUI = 10'h005;
   localparam logic [9:0] CTRL_SW  = 10'h011;
   localparam logic [9:0] CTRL_ADI = 10'h045;

   logic              clk;
   logic              reset;
   logic [6:0]        id_opcode;
   logic [9:0]        id_ctrl;
   logic              id_valid;
   logic [XLEN-1:0]   id_pc, id_rd1, id_rd2, id_imm;
   logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
   logic [2:0]        id_funct3;
   logic [6:0]        id_funct7;
   logic              hold_in;
   logic              ex_flush;
   logic [9:0]        ex_ctrl;
   logic              ex_valid;
   logic [XLEN-1:0]   ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
   logic [2:0]        ex_funct3;
   logic [6:0]        ex_funct7;
   logic              pc_write, if_id_write, stall;
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0]       stall_cnt, flush_cnt;
`endif

   int tests;
   int fails;

   id_ex_hazard_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .clk(clk), .reset(reset),
      .id_opcode(id_opcode), .id_ctrl(id_ctrl), .id_valid(id_valid),
      .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_funct3(id_funct3), .id_funct7(id_funct7),
      .hold_in(hold_in), .ex_flush(ex_flush),
      .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
`ifdef ID_EX_PERF_CNT_EN
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
      .pc_write(pc_write), .if_id_write(if_id_write), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish before 200000ns");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setId(input logic [6:0] op, input logic [9:0] ctrl, input logic v,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] pc);
      id_opcode = op;  id_ctrl = ctrl; id_valid = v;
      id_rs1 = rs1;    id_rs2 = rs2;   id_rd = rd;
      id_pc = pc;      id_rd1 = pc ^ 32'h1111_0000; id_rd2 = pc ^ 32'h2222_0000;
      id_imm = pc + 32'd4; id_funct3 = 3'd0; id_funct7 = 7'd0;
      #1;
   endtask

   task automatic chkBit(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; hold_in = 1'b0; ex_flush = 1'b0;
      setId(7'($urandom), 10'($urandom), 1'b1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      repeat (3) tick();
      tests++; if (ex_ctrl !== 10'h000) begin fails++; $display("FAIL reset_ctrl: got %h, required 000", ex_ctrl); end
      tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", ex_valid); end
      tests++; if (ex_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h, required 0", ex_pc); end
      tests++; if ({pc_write, if_id_write, stall} !== 3'b110) begin fails++; $display("FAIL reset_comb: got pc/ifid/stall %b, required 110", {pc_write, if_id_write, stall}); end
      reset = 1'b1;
      #1;
      tests++; if (ex_ctrl !== 10'h000 || ex_valid !== 1'b0) begin fails++; $display("FAIL reset_release: got ctrl %h valid %b, required 000/0", ex_ctrl, ex_valid); end
      setId(OP_ITYPE, CTRL_ADI, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
      tick();
      $display("[TB] reset sequence done");
   endtask

   task automatic test_load_use();
      setId(OP_LOAD, CTRL_LW, 1'b1, 5'd1, 5'd0, 5'd5, 32'h100);
      tick();
      tests++; if (ex_ctrl !== CTRL_LW || ex_rd !== 5'd5) begin fails++; $display("FAIL lu_load_in_ex: got ctrl %h rd %0d, required %h/5", ex_ctrl, ex_rd, CTRL_LW); end
      setId(OP_RTYPE, CTRL_ADD, 1'b1, 5'd5, 5'd7, 5'd6, 32'h104);
      tests++; if ({stall, pc_write, if_id_write} !== 3'b100) begin fails++; $display("FAIL lu_stall: got stall/pc/ifid %b, required 100", {stall, pc_write, if_id_write}); end
      tick();
      tests++; if (ex_ctrl !== 10'h000 || ex_valid !== 1'b0) begin fails++; $display("FAIL lu_bubble: got ctrl %h valid %b, required 000/0", ex_ctrl, ex_valid); end
      tests++; if ({stall, pc_write, if_id_write} !== 3'b011) begin fails++; $display("FAIL lu_one_cycle: got stall/pc/ifid %b, required 011", {stall, pc_write, if_id_write}); end
      tick();
      tests++; if (ex_ctrl !== CTRL_ADD || ex_rs1 !== 5'd5 || ex_valid !== 1'b1 || ex_pc !== 32'h104) begin fails++; $display("FAIL lu_add_in_ex: got ctrl %h rs1 %0d valid %b pc %h, required %h/5/1/104", ex_ctrl, ex_rs1, ex_valid, ex_pc, CTRL_ADD); end
      $display("[TB] lw x5 / add x6,x5,x7 done");
   endtask

   task automatic test_x0_and_use();
      setId(OP_LOAD, CTRL_LW, 1'b1, 5'd1, 5'd0, 5'd0, 32'h200);
      tick();
      setId(OP_RTYPE, CTRL_ADD, 1'b1, 5'd0, 5'd0, 5'd6, 32'h204);
      chkBit("x0_no_stall", stall, 1'b0);
      tick();
      tests++; if (ex_ctrl !== CTRL_ADD || ex_pc !== 32'h204) begin fails++; $display("FAIL x0_add_in_ex: got ctrl %h pc %h, required %h/204", ex_ctrl, ex_pc, CTRL_ADD); end
      $display("[TB] lw x0 / add rs1=x0 done");

      setId(OP_LOAD, CTRL_LW, 1'b1, 5'd1, 5'd0, 5'd5, 32'h300);
      tick();
      setId(OP_LUI, CTRL_LUI, 1'b1, 5'd5, 5'd5, 5'd5, 32'h304);
      chkBit("lui_no_stall", stall, 1'b0);
      setId(OP_ITYPE, CTRL_ADI, 1'b1, 5'd2, 5'd5, 5'd8, 32'h304);
      chkBit("itype_rs2_no_stall", stall, 1'b0);
      setId(OP_STORE, CTRL_SW, 1'b1, 5'd2, 5'd5, 5'd0, 32'h304);
      chkBit("store_rs2_stall", stall, 1'b1);
      setId(OP_STORE, CTRL_SW, 1'b0, 5'd2, 5'd5, 5'd0, 32'h304);
      chkBit("invalid_id_no_stall", stall, 1'b0);
      setId(OP_LUI, CTRL_LUI, 1'b1, 5'd5, 5'd5, 5'd5, 32'h304);
      tick();
      tests++; if (ex_ctrl !== CTRL_LUI || ex_valid !== 1'b1) begin fails++; $display("FAIL lui_in_ex: got ctrl %h valid %b, required %h/1", ex_ctrl, ex_valid, CTRL_LUI); end
      $display("[TB] lw x5 / lui x5 and rs2-use checks done");
   endtask

   task automatic test_invalid();
      setId(OP_RTYPE, CTRL_ADD, 1'b0, 5'd3, 5'd4, 5'd9, 32'h400);
      tick();
      tests++; if (ex_ctrl !== 10'h000 || ex_valid !== 1'b0) begin fails++; $display("FAIL invalid_bubble: got ctrl %h valid %b, required 000/0", ex_ctrl, ex_valid); end
      $display("[TB] invalid ID instruction done");
   endtask

   task automatic test_flush_collision();
      setId(OP_LOAD, CTRL_LW, 1'b1, 5'd1, 5'd0, 5'd5, 32'h500);
      tick();
      setId(OP_RTYPE, CTRL_ADD, 1'b1, 5'd5, 5'd7, 5'd6, 32'h504);
      ex_flush = 1'b1;
      #1;
      tests++; if ({stall, pc_write, if_id_write} !== 3'b011) begin fails++; $display("FAIL flush_lu_comb: got stall/pc/ifid %b, required 011", {stall, pc_write, if_id_write}); end
      tick();
      ex_flush = 1'b0;
      tests++; if (ex_ctrl !== 10'h000 || ex_valid !== 1'b0) begin fails++; $display("FAIL flush_bubble: got ctrl %h valid %b, required 000/0", ex_ctrl, ex_valid); end
      $display("[TB] flush with load-use done");
   endtask

   task automatic test_hold();
      setId(OP_LOAD, CTRL_LW, 1'b1, 5'd1, 5'd0, 5'd5, 32'h600);
      tick();
      setId(OP_RTYPE, CTRL_ADD, 1'b1, 5'd5, 5'd7, 5'd6, 32'h604);
      hold_in = 1'b1; ex_flush = 1'b1;
      #1;
      tests++; if ({stall, pc_write, if_id_write} !== 3'b000) begin fails++; $display("FAIL hold_comb: got stall/pc/ifid %b, required 000", {stall, pc_write, if_id_write}); end
      tick();
      tick();
      tests++; if (ex_ctrl !== CTRL_LW || ex_valid !== 1'b1 || ex_pc !== 32'h600 || ex_rd !== 5'd5) begin fails++; $display("FAIL hold_keep: got ctrl %h valid %b pc %h rd %0d, required %h/1/600/5", ex_ctrl, ex_valid, ex_pc, ex_rd, CTRL_LW); end
      hold_in = 1'b0; ex_flush = 1'b0;
      #1;
      chkBit("hold_release_stall", stall, 1'b1);
      tick();
      tick();
      tests++; if (ex_ctrl !== CTRL_ADD || ex_pc !== 32'h604) begin fails++; $display("FAIL hold_then_add: got ctrl %h pc %h, required %h/604", ex_ctrl, ex_pc, CTRL_ADD); end
      $display("[TB] hold with flush done");
   endtask

   task automatic test_reset_mid_stall();
      setId(OP_LOAD, CTRL_LW, 1'b1, 5'd1, 5'd0, 5'd5, 32'h700);
      tick();
      setId(OP_RTYPE, CTRL_ADD, 1'b1, 5'd5, 5'd7, 5'd6, 32'h704);
      chkBit("mid_stall_pre", stall, 1'b1);
      reset = 1'b0;
      #1;
      tests++; if (ex_ctrl !== 10'h000 || stall !== 1'b0 || pc_write !== 1'b1) begin fails++; $display("FAIL async_reset: got ctrl %h stall %b pc_write %b, required 000/0/1", ex_ctrl, stall, pc_write); end
      reset = 1'b1;
      tick();
      tests++; if (ex_ctrl !== CTRL_ADD || ex_valid !== 1'b1) begin fails++; $display("FAIL reset_then_load: got ctrl %h valid %b, required %h/1", ex_ctrl, ex_valid, CTRL_ADD); end
      $display("[TB] reset mid-stall done");
   endtask

`ifdef ID_EX_PERF_CNT_EN
   task automatic test_perf_cnt();
      reset = 1'b0;
      #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         setId(OP_LOAD, CTRL_LW, 1'b1, 5'd1, 5'd0, 5'd5, 32'h800);
         tick();
         setId(OP_RTYPE, CTRL_ADD, 1'b1, 5'd5, 5'd7, 5'd6, 32'h804);
         tick();
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         setId(OP_RTYPE, CTRL_ADD, 1'b1, 5'd2, 5'd3, 5'd4, 32'h900);
         ex_flush = 1'b1;
         tick();
         ex_flush = 1'b0;
         tick();
      end
      hold_in = 1'b1; ex_flush = 1'b1;
      tick();
      hold_in = 1'b0; ex_flush = 1'b0;
      tests++; if (stall_cnt !== 32'd3) begin fails++; $display("FAIL stall_cnt: got %0d, required 3", stall_cnt); end
      tests++; if (flush_cnt !== 32'd2) begin fails++; $display("FAIL flush_cnt: got %0d, required 2", flush_cnt); end
      reset = 1'b0;
      #1;
      tests++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin fails++; $display("FAIL cnt_reset: got %0d/%0d, required 0/0", stall_cnt, flush_cnt); end
      reset = 1'b1;
      tick();
      $display("[TB] performance counters done");
   endtask
`endif

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_load_use();
      test_x0_and_use();
      test_invalid();
      test_flush_collision();
      test_hold();
      test_reset_mid_stall();
`ifdef ID_EX_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register with integrated load-use hazard detection.
- Sits directly downstream of the opcode decoder. Captures the decoded control bundle plus ID-stage operands each cycle and presents them to EX.
- Generates the PC/IF-ID write enables for stalls.
- Inserts bubbles on load-use stalls and on EX-resolved control-flow flushes.

Parameters:
- XLEN, 32, datapath width for pc, rd1, rd2, imm.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  stage clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_opcode  in  7  opcode of the instruction in ID.
- id_ctrl  in  10  decoder bundle: [0]ALUSrc [1]MemtoReg [2]RegWrite [3]MemRead [4]MemWrite [6:5]ALUOp [7]Branch [8]JalSel [9]JalrSel.
- id_valid  in  1  ID holds a real instruction.
- id_pc, id_rd1, id_rd2, id_imm  in  XLEN each  ID operands.
- id_rs1, id_rs2, id_rd  in  REG_AW each  register addresses.
- id_funct3  in  3  / id_funct7  in  7  ALU-control fields.
- hold_in  in  1  global freeze from downstream (memory wait).
- ex_flush  in  1  branch/jump taken in EX; kill the instruction in ID.
- ex_ctrl  out  10  registered bundle, same bit order as id_ctrl.
- ex_valid  out  1  registered valid.
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN  registered operands.
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered addresses.
- ex_funct3  out  3  / ex_funct7  out  7  registered fields.
- pc_write  out  1  combinational; 0 stalls the PC.
- if_id_write  out  1  combinational; 0 freezes IF/ID.
- stall  out  1  combinational load-use indication.

Behaviour:
- Reset (reset==0, asynchronous):
  - All registered outputs = 0, ex_valid = 0. This is a bubble.
  - Combinational outputs evaluate against that state: pc_write = 1, if_id_write = 1, stall = 0.
  - Reset mid-stall or mid-flush discards all pending state; the first cycle after release is a normal load.
- rs1 use: uses_rs1 = 1 for all opcodes except LUI (0110111) and JAL (1101111).
- rs2 use: uses_rs2 = 1 only for R-type (0110011), store (0100011) and branch (1100011).
- Load-use detection:
  - load_use = ex_valid & ex_ctrl[3] & (ex_rd != 0) & id_valid & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- Priority per edge, highest first:
  1. hold_in: all ex_* registers keep their value.
  2. ex_flush: load bubble (ex_ctrl = 0, ex_valid = 0). Data fields load from id_* (don't care).
  3. load_use: load bubble as above. ID is held by the enables below.
  4. Otherwise: load every id_* input into ex_*. ex_valid = id_valid. ex_ctrl = id_valid ? id_ctrl : 0.
- Combinational outputs:
  - stall = load_use & ~ex_flush & ~hold_in.
  - pc_write = ~(stall | hold_in).
  - if_id_write = ~(stall | hold_in).
- Stall length: exactly one cycle per load-use. After the bubble enters EX, ex_ctrl[3] = 0, so the hazard clears. A back-to-back dependent pair costs 1 bubble.
- x0 rule: a load targeting x0 never stalls.
- Flush and load_use in the same cycle: flush wins and stall = 0, because the dependent instruction is being killed.
- Latency: 1 cycle from ID inputs to ex_* outputs.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, add two outputs: stall_cnt [31:0] and flush_cnt [31:0].
  - stall_cnt increments on each edge where stall==1.
  - flush_cnt increments on each edge where ex_flush==1 & ~hold_in.
  - Both wrap from 0xFFFFFFFF to 0, clear on reset, and do not count while hold_in==1.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset sequence: reset low with random id_*, then release → ex_ctrl = 0, ex_valid = 0, pc_write = 1, if_id_write = 1 until the first edge after release.
- lw x5 followed by add x6,x5,x7 (opcode 0110011, rs1 = 5):
  - stall = 1, pc_write = 0, if_id_write = 0 for exactly 1 cycle.
  - Next ex_ctrl = 0, then the add's bundle appears in EX with ex_rs1 = 5.
- lw x0 followed by add using rs1 = 0 → stall never asserts; add enters EX next cycle.
- lw x5 followed by lui x5 (rs1 field = 5) → no stall, since uses_rs1 = 0.
- Flush collisions:
  - ex_flush = 1 in the same cycle as a load-use hazard → stall = 0, pc_write = 1, next ex_valid = 0 and ex_ctrl = 0.
  - hold_in = 1 with ex_flush = 1 → ex_* unchanged, pc_write = 0.
- ID_EX_PERF_CNT_EN defined, three separate load-use pairs and two flushes → stall_cnt = 3, flush_cnt = 2. Reset mid-run → both counters = 0.
